spi_cmd_sequencer: RTL and testbench

//  Command queue and sequencer in front of spi_ctrl, replacing direct CPU-driven starts.
//  The CPU pushes {dc, end_txn, byte} commands into a small FIFO.
//  The sequencer issues each command to spi_ctrl back-to-back and captures the received byte.
//  The CPU can therefore stream display/flash bytes without polling the busy bit per byte.

---
 rtl/spi_cmd_sequencer_pkg.sv | 23 ++
 rtl/spi_cmd_sequencer_cmd_fifo.sv | 60 ++++++
 rtl/spi_cmd_sequencer.sv | 145 ++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared types and constants for the SPI command sequencer and its FIFO.
package spi_cmd_sequencer_pkg;

    localparam int unsigned BYTE_W = 8;

    // Command word as pushed by the CPU: {dc, end_txn, byte}
    typedef struct packed {
        logic              dc;
        logic              end_txn;
        logic [BYTE_W-1:0] data;
    } cmd_t;

    localparam int unsigned CMD_W   = $bits(cmd_t);
    localparam int unsigned DC_BIT  = 9;
    localparam int unsigned END_BIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/spi_cmd_sequencer_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible combinationally on rdata.
module cmd_fifo
    import spi_cmd_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic                  pop,
    input  logic [CMD_W-1:0]      wdata,
    output logic [CMD_W-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [CMD_W-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Queues CPU commands and issues them back-to-back to spi_ctrl, capturing rx bytes.
module spi_cmd_sequencer
    import spi_cmd_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    input  logic [CMD_W-1:0]      cmd_data,
    output logic                  cmd_full,
    output logic [DEPTH_LOG2:0]   cmd_count,
    input  logic                  rx_read,
    output logic [BYTE_W-1:0]     rx_data,
    output logic                  rx_valid,
    output logic                  err_drop,
    output logic                  err_overrun,
    input  logic                  clr_err,
    output logic                  idle,
    output logic                  spi_start,
    output logic [BYTE_W-1:0]     spi_data,
    output logic                  spi_dc,
    output logic                  spi_end_txn,
    input  logic                  spi_busy,
    input  logic [BYTE_W-1:0]     spi_rx_data
);

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic              start_d;
    logic [BYTE_W-1:0] data_d;
    logic              dc_d;
    logic              end_d;
    logic              issue_c;
    logic              capture_c;
    logic              fifo_empty;
    logic [CMD_W-1:0]  fifo_rdata;
    logic              drop_evt;
    logic              overrun_evt;

    cmd_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (cmd_valid && !cmd_full),
        .pop   (issue_c),
        .wdata (cmd_data),
        .rdata (fifo_rdata),
        .full  (cmd_full),
        .empty (fifo_empty),
        .count (cmd_count)
    );

    assign idle        = (state_q == ST_IDLE) && fifo_empty && !spi_busy;
    assign drop_evt    = cmd_valid && cmd_full;
    assign overrun_evt = capture_c && rx_valid && !rx_read;

    // Next-state and next-output decode; WAIT chains straight into the next
    // issue so back-to-back spacing is busy time + 2 cycles
    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        data_d    = spi_data;
        dc_d      = spi_dc;
        end_d     = spi_end_txn;
        issue_c   = 1'b0;
        capture_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !spi_busy) begin
                    issue_c = 1'b1;
                end
            end
            ST_ARM: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!spi_busy) begin
                    capture_c = 1'b1;
                    if (!fifo_empty) begin
                        issue_c = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (issue_c) begin
            state_d = ST_ARM;
            start_d = 1'b1;
            data_d  = fifo_rdata[BYTE_W-1:0];
            dc_d    = fifo_rdata[DC_BIT];
            end_d   = fifo_rdata[END_BIT];
        end
    end

    // FSM state and registered spi_ctrl drive
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            spi_start   <= 1'b0;
            spi_data    <= '0;
            spi_dc      <= 1'b0;
            spi_end_txn <= 1'b0;
        end else begin
            state_q     <= state_d;
            spi_start   <= start_d;
            spi_data    <= data_d;
            spi_dc      <= dc_d;
            spi_end_txn <= end_d;
        end
    end

    // Receive capture and sticky error flags; a new error beats clr_err
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            err_drop    <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (capture_c) begin
                rx_data  <= spi_rx_data;
                rx_valid <= 1'b1;
            end else if (rx_read) begin
                rx_valid <= 1'b0;
            end
            if (drop_evt) begin
                err_drop <= 1'b1;
            end else if (clr_err) begin
                err_drop <= 1'b0;
            end
            if (overrun_evt) begin
                err_overrun <= 1'b1;
            end else if (clr_err) begin
                err_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench with an issue scoreboard and a simple spi_ctrl model.
module tb_spi_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [9:0] cmd_data = '0;
    logic       cmd_full;
    logic [2:0] cmd_count;
    logic       rx_read = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       err_drop;
    logic       err_overrun;
    logic       clr_err = 1'b0;
    logic       idle;
    logic       spi_start;
    logic [7:0] spi_data;
    logic       spi_dc;
    logic       spi_end_txn;
    logic       spi_busy;
    logic [7:0] spi_rx_data;

    // spi_ctrl model state
    logic       m_busy;
    logic [4:0] m_cnt;
    logic [7:0] m_dout;
    logic       ext_busy = 1'b0;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    spi_cmd_sequencer #(.DEPTH_LOG2(2)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .cmd_full    (cmd_full),
        .cmd_count   (cmd_count),
        .rx_read     (rx_read),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .err_drop    (err_drop),
        .err_overrun (err_overrun),
        .clr_err     (clr_err),
        .idle        (idle),
        .spi_start   (spi_start),
        .spi_data    (spi_data),
        .spi_dc      (spi_dc),
        .spi_end_txn (spi_end_txn),
        .spi_busy    (spi_busy),
        .spi_rx_data (spi_rx_data)
    );

    assign spi_busy    = m_busy | ext_busy;
    assign spi_rx_data = m_dout;

    // spi_ctrl: busy one cycle after start for 16 cycles, returns ~data_in
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy <= 1'b0;
            m_cnt  <= '0;
            m_dout <= '0;
        end else if (spi_start && !m_busy) begin
            m_busy <= 1'b1;
            m_cnt  <= 5'd16;
            m_dout <= ~spi_data;
        end else if (m_busy) begin
            m_cnt <= m_cnt - 5'd1;
            if (m_cnt == 5'd1) m_busy <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue monitor: every start must match the oldest accepted command
    always @(negedge clk) begin
        if (rstn && spi_start) begin
            start_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected actual=%0h expected=none",
                         {spi_dc, spi_end_txn, spi_data});
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({spi_dc, spi_end_txn, spi_data} !== e) begin
                    errors++;
                    $display("FAIL issue_order actual=%0h expected=%0h",
                             {spi_dc, spi_end_txn, spi_data}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] d);
        cmd_valid = 1'b1;
        cmd_data  = d;
        exp_q.push_back(d);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!idle && n < budget) begin
            tick();
            n++;
        end
        if (!idle) chk("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_start(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!spi_start && n < budget);
        if (!spi_start) chk("wait_start_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {cmd_full, cmd_count, rx_data, rx_valid, err_drop, err_overrun,
                   spi_start, spi_data, spi_dc, spi_end_txn}, 32'd0);
        chk({name, "_idle"}, idle, 1'b1);
    endtask

    initial begin
        int n;
        int s0;
        logic [9:0] burst [5];
        burst = '{10'h101, 10'h202, 10'h303, 10'h004, 10'h1F5};

        // 1: reset state, then reset mid-WAIT
        #1;
        check_reset_outputs("reset");
        tick(); tick();
        rstn = 1'b1;
        tick();
        push(10'h0AA);
        wait_start(10, n);
        repeat (5) tick();
        rstn = 1'b0;
        #1;
        check_reset_outputs("reset_mid_wait");
        tick(); tick();
        rstn = 1'b1;
        s0 = start_cnt;
        repeat (30) tick();
        chk("no_start_after_reset", start_cnt - s0, 0);

        // 2: single command latency and capture
        push(10'h2A5);
        chk("start_not_early", spi_start, 1'b0);
        tick();
        chk("start_latency", spi_start, 1'b1);
        chk("issue_fields", {spi_dc, spi_end_txn, spi_data}, 10'h2A5);
        wait_idle(60);
        chk("rx_data_single", rx_data, 8'h5A);
        chk("rx_valid_single", rx_valid, 1'b1);
        chk("idle_single", idle, 1'b1);

        // 3: burst of five fills the FIFO, sixth is dropped
        rx_read = 1'b1; tick(); rx_read = 1'b0;
        chk("rx_read_clears", rx_valid, 1'b0);
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = burst[i];
            exp_q.push_back(burst[i]);
            tick();
            if (i == 3) chk("full_after_4th", cmd_full, 1'b0);
            if (i == 4) begin
                chk("full_after_5th", cmd_full, 1'b1);
                chk("count_full", cmd_count, 3'd4);
            end
        end
        cmd_data = 10'h3FF;
        tick();
        cmd_valid = 1'b0;
        chk("err_drop_set", err_drop, 1'b1);
        chk("count_after_drop", cmd_count, 3'd4);
        wait_idle(200);
        chk("burst_start_count", start_cnt - s0, 5);
        chk("burst_queue_drained", exp_q.size(), 0);

        // 4: overrun without rx_read, then clr_err
        rx_read = 1'b1; clr_err = 1'b1; tick(); rx_read = 1'b0; clr_err = 1'b0;
        chk("errors_cleared_pre4", {err_drop, err_overrun, rx_valid}, 3'b000);
        push(10'h111);
        push(10'h0F0);
        wait_idle(100);
        chk("overrun_set", err_overrun, 1'b1);
        chk("overrun_data", rx_data, 8'h0F);
        chk("overrun_valid", rx_valid, 1'b1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_err", {err_drop, err_overrun}, 2'b00);
        chk("clr_keeps_valid", rx_valid, 1'b1);

        // 5: rx_read coincident with capture
        push(10'h3C3);
        wait_start(10, n);
        repeat (17) tick();
        chk("pre_capture_data", rx_data, 8'h0F);
        rx_read = 1'b1; tick(); rx_read = 1'b0;
        chk("coincident_valid", rx_valid, 1'b1);
        chk("coincident_no_overrun", err_overrun, 1'b0);
        chk("coincident_data", rx_data, 8'h3C);
        wait_idle(20);

        // 6: external busy holds off issue; back-to-back spacing
        ext_busy = 1'b1;
        push(10'h055);
        push(10'h1AA);
        for (int i = 0; i < 10; i++) begin
            chk("held_off_by_busy", spi_start, 1'b0);
            tick();
        end
        ext_busy = 1'b0;
        wait_start(10, n);
        wait_start(40, n);
        chk("issue_spacing", n, 18);
        wait_idle(40);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
